// File: rtl/mmio_timer_periph_if.sv
// CPU data-bus connection for the timer/IO peripheral.
// The CPU drives the strobes, address and store data; the peripheral
// returns read data that the CPU ORs with the other bus slaves.
interface mmio_timer_periph_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output rd,
        output wr,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  rd,
        input  wr,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_timer_periph.sv
// Memory-mapped peripheral: interval timer with interrupt, LED, switch,
// 7-segment and free-running systick registers.
// Reads are combinational (single-cycle CPU); writes commit on posedge clk.
//
// offset | register | width
// 0x00   | TH       | 32  reload value
// 0x04   | TL       | 32  count, counts up while TCON[0]
// 0x08   | TCON     | 3   [0] enable, [1] irq enable, [2] irq status
// 0x0C   | LED      | 8
// 0x10   | SWITCH   | 8   read-only, sampled live
// 0x14   | DIGI     | 12  [11:8] anode select, [7:0] segments
// 0x18   | SYSTICK  | 32  read-only, +1 every clock
module mmio_timer_periph #(
    parameter logic [31:0] BASE     = 32'h40000000,
    parameter logic [31:0] TL_RESET = 32'h00000000
) (
    input  logic                      clk,
    input  logic                      reset,
    mmio_timer_periph_if.slave        bus,
    output logic                      irqout,
    output logic [7:0]                led,
    input  logic [7:0]                switch,
    output logic [11:0]               digi
);

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_SWITCH  = 3'd4;
    localparam logic [2:0] OFF_DIGI    = 3'd5;
    localparam logic [2:0] OFF_SYSTICK = 3'd6;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q, systick_d;

    logic        sel;
    logic [2:0]  reg_idx;
    logic        wr_en;
    logic        overflow;
    logic        unused_addr_lsb;

    // Address decode: byte lanes are ignored, offsets 0x1C and 0x1D.. unselected
    assign reg_idx         = bus.addr[4:2];
    assign sel             = (bus.addr[31:5] == BASE[31:5]) && (reg_idx <= OFF_SYSTICK);
    assign wr_en           = bus.wr && sel;
    assign unused_addr_lsb = ^bus.addr[1:0];

    // Timer wraps when it is enabled and sitting at all-ones
    assign overflow = tcon_q[0] && (tl_q == 32'hFFFFFFFF);

    // Next-state: timer/systick housekeeping first, bus writes override after
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;

        if (tcon_q[0]) begin
            if (overflow) begin
                // Reload uses the TH already in the register, so a TH write
                // on this same edge only affects the following overflow.
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (wr_en) begin
            unique case (reg_idx)
                OFF_TH: begin
                    th_d = bus.wdata;
                end
                OFF_TL: begin
                    // Software load beats both count and reload
                    tl_d = bus.wdata;
                end
                OFF_TCON: begin
                    // A status clear racing an overflow must not lose it
                    tcon_d = bus.wdata[2:0];
                    if (overflow && tcon_q[1]) begin
                        tcon_d[2] = 1'b1;
                    end
                end
                OFF_LED: begin
                    led_d = bus.wdata[7:0];
                end
                OFF_DIGI: begin
                    digi_d = bus.wdata[11:0];
                end
                default: begin
                    // SWITCH and SYSTICK are read-only
                end
            endcase
        end
    end

    // Register file state, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= TL_RESET;
            tl_q      <= TL_RESET;
            tcon_q    <= 3'b000;
            led_q     <= 8'h00;
            digi_q    <= 12'h000;
            systick_q <= 32'h00000000;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    // Read mux: zero unless this slave is selected, so the CPU can OR slaves
    always_comb begin
        bus.rdata = 32'h00000000;
        if (bus.rd && sel) begin
            unique case (reg_idx)
                OFF_TH:      bus.rdata = th_q;
                OFF_TL:      bus.rdata = tl_q;
                OFF_TCON:    bus.rdata = {29'd0, tcon_q};
                OFF_LED:     bus.rdata = {24'd0, led_q};
                OFF_SWITCH:  bus.rdata = {24'd0, switch};
                OFF_DIGI:    bus.rdata = {20'd0, digi_q};
                OFF_SYSTICK: bus.rdata = systick_q;
                default:     bus.rdata = 32'h00000000;
            endcase
        end
    end

    assign irqout = tcon_q[2] & tcon_q[1];
    assign led    = led_q;
    assign digi   = digi_q;

endmodule

// File: tb/tb_mmio_timer_periph.sv
// Directed bench for mmio_timer_periph. Stimulus pushes expected values into
// a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_mmio_timer_periph;

    localparam logic [31:0] BASE = 32'h40000000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_LED  = BASE + 32'h0C;
    localparam logic [31:0] A_SW   = BASE + 32'h10;
    localparam logic [31:0] A_DIGI = BASE + 32'h14;
    localparam logic [31:0] A_TICK = BASE + 32'h18;

    localparam int K_RDATA = 0;
    localparam int K_IRQ   = 1;
    localparam int K_LED   = 2;
    localparam int K_DIGI  = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } sb_item_t;

    logic        clk;
    logic        reset;
    logic        irqout;
    logic [7:0]  led;
    logic [7:0]  switch_in;
    logic [11:0] digi;

    mmio_timer_periph_if bus ();

    mmio_timer_periph #(
        .BASE     (BASE),
        .TL_RESET (32'h00000000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .irqout (irqout),
        .led    (led),
        .switch (switch_in),
        .digi   (digi)
    );

    sb_item_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every pending expectation against the DUT mid-cycle
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            sb_item_t    it;
            logic [31:0] act;
            it = sb_q.pop_front();
            case (it.kind)
                K_IRQ:   act = {31'd0, irqout};
                K_LED:   act = {24'd0, led};
                K_DIGI:  act = {20'd0, digi};
                default: act = bus.rdata;
            endcase
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
            end
        end
    end

    task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
        sb_item_t it;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb_q.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus.rd   = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = a;
        expect_val(K_RDATA, exp, name);
        tick();
        bus.rd = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.rd    = 1'b0;
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        switch_in = 8'h00;

        // Reset state
        tick();
        expect_val(K_IRQ,  32'h0, "reset_irq");
        expect_val(K_LED,  32'h0, "reset_led");
        expect_val(K_DIGI, 32'h0, "reset_digi");
        bus_read(A_TCON, 32'h0, "reset_tcon");
        reset = 1'b0;

        // Systick after exactly 100 edges out of reset
        repeat (100) tick();
        bus_read(A_TICK, 32'd100, "systick_100");
        bus_read(A_TCON, 32'h0, "tcon_after_reset");

        // Overflow and interrupt
        bus_write(A_TH, 32'hFFFFFFFC);
        bus_write(A_TL, 32'hFFFFFFFD);
        bus_write(A_TCON, 32'h3);
        bus_read(A_TL, 32'hFFFFFFFD, "tl_start");
        bus_read(A_TL, 32'hFFFFFFFE, "tl_fe");
        expect_val(K_IRQ, 32'h0, "irq_before_ovf");
        bus_read(A_TL, 32'hFFFFFFFF, "tl_ff");
        expect_val(K_IRQ, 32'h1, "irq_on_reload");
        bus_read(A_TL, 32'hFFFFFFFC, "tl_reload");
        expect_val(K_IRQ, 32'h1, "irq_held");
        bus_write(A_TCON, 32'h3);
        expect_val(K_IRQ, 32'h0, "irq_acked");
        bus_read(A_TL, 32'hFFFFFFFE, "tl_after_ack");
        expect_val(K_IRQ, 32'h0, "irq_still_low");
        tick();
        expect_val(K_IRQ, 32'h1, "irq_reassert");
        bus_read(A_TL, 32'hFFFFFFFC, "tl_reload2");

        // Clear racing the overflow edge
        bus_write(A_TCON, 32'h3);
        expect_val(K_IRQ, 32'h0, "irq_cleared_pre_race");
        bus_read(A_TCON, 32'h3, "tcon_cleared");
        bus_write(A_TCON, 32'h3);
        expect_val(K_IRQ, 32'h1, "irq_race_kept");
        bus_read(A_TCON, 32'h7, "tcon_race");

        // Software TL load wins over counting
        bus_write(A_TL, 32'h00000010);
        bus_read(A_TL, 32'h00000010, "tl_write_wins");

        // TH write on the overflow edge: reload uses old TH
        bus_write(A_TL, 32'hFFFFFFFE);
        tick();
        bus_write(A_TH, 32'h00000100);
        bus_read(A_TL, 32'hFFFFFFFC, "tl_old_th_reload");
        bus_read(A_TH, 32'h00000100, "th_new");

        // Disable: TL holds
        bus_write(A_TCON, 32'h0);
        bus_read(A_TL, 32'hFFFFFFFF, "tl_hold_a");
        bus_read(A_TL, 32'hFFFFFFFF, "tl_hold_b");
        expect_val(K_IRQ, 32'h0, "irq_disabled");

        // LED, DIGI, SWITCH
        bus_write(A_LED, 32'h000000A5);
        expect_val(K_LED, 32'hA5, "led_out");
        bus_write(A_DIGI, 32'hFFFF0E3C);
        expect_val(K_DIGI, 32'hE3C, "digi_out");
        switch_in = 8'h5A;
        bus_read(A_SW, 32'h0000005A, "switch_read");
        bus_read(A_LED, 32'h000000A5, "led_read");
        bus_read(A_DIGI, 32'h00000E3C, "digi_read");
        bus_read(BASE + 32'h0F, 32'h000000A5, "byte_lane_ignored");

        // Decode and isolation
        bus_read(BASE + 32'h1C, 32'h0, "unsel_1c");
        bus_read(32'h00000010, 32'h0, "unsel_low");
        bus_read(32'h40000100, 32'h0, "unsel_above");
        bus_write(32'h00000008, 32'h3);
        bus_read(A_TCON, 32'h0, "tcon_unaliased");
        bus.rd   = 1'b0;
        bus.addr = A_LED;
        expect_val(K_RDATA, 32'h0, "rd_low_zero");
        tick();

        // Async reset while the timer runs with an interrupt pending
        bus_write(A_TL, 32'hFFFFFFFF);
        bus_write(A_TCON, 32'h3);
        tick();
        expect_val(K_IRQ, 32'h1, "irq_before_reset");
        tick();
        reset    = 1'b1;
        bus.rd   = 1'b1;
        bus.addr = A_TL;
        expect_val(K_RDATA, 32'h0, "async_tl");
        expect_val(K_IRQ,   32'h0, "async_irq");
        expect_val(K_LED,   32'h0, "async_led");
        expect_val(K_DIGI,  32'h0, "async_digi");
        @(negedge clk);
        #1;
        reset  = 1'b0;
        bus.rd = 1'b0;
        tick();
        bus_read(A_TCON, 32'h0, "post_reset_tcon");
        bus_read(A_TL, 32'h0, "post_reset_tl_idle");
        bus_read(A_TICK, 32'd3, "post_reset_systick");

        tick();
        tick();
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
